// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer: queues bus-drive requests from N sources and issues
// one one-hot grant at a time in round-robin order, handshaken by grant_ack.
// The one-hot grant feeds the 32-to-5 bus-select encoder directly.
module bus_drive_sequencer #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic                 req_valid,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid,
    input  logic                 grant_ack,
    output logic [N-1:0]         pending,
    output logic                 busy
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q,   state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    grant_q,   grant_d;
    logic [IW-1:0]   idx_q,     idx_d;
    logic [IW-1:0]   ptr_q,     ptr_d;

    logic [N-1:0]    req_in;
    logic [N-1:0]    cand;
    logic [2*N-1:0]  cand_dbl;
    logic [N-1:0]    cand_rot;
    logic [IW-1:0]   sel_off;
    logic [IW-1:0]   sel;
    logic            issue;

    // Round-robin pick: rotate the candidate set so ptr sits at bit 0, take
    // the lowest set bit, then map the offset back. N is a power of two, so
    // the IW-bit add wraps mod N on its own.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        req_in   = req_valid ? req : '0;
        cand     = pending_q | req_in;
        cand_dbl = {cand, cand};
        cand_rot = cand_dbl[ptr_q +: N];
        sel_off  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                sel_off = IW'(i);
            end
        end
        sel = ptr_q + sel_off;
    end

    // Next-state: issue a new grant when idle or when the current one is
    // acked; otherwise hold the grant and keep collecting requests.
    always_comb begin
        issue     = (state_q == IDLE) || grant_ack;
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        if (issue) begin
            if (|cand) begin
                state_d   = GRANT;
                grant_d   = N'(1) << sel;
                idx_d     = sel;
                pending_d = cand & ~(N'(1) << sel);
                ptr_d     = sel + IW'(1);
            end else begin
                state_d   = IDLE;
                grant_d   = '0;
                idx_d     = '0;
                pending_d = '0;
            end
        end else begin
            pending_d = cand;
        end
    end

    // State registers with synchronous active-low clear; a clear also drops
    // any live grant without waiting for an ack.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!clr) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == GRANT);
    assign pending     = pending_q;
    assign busy        = grant_valid | (|pending_q);

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Testbench for bus_drive_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the queue-and-round-robin rules.
module tb_bus_drive_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] req;
    logic        req_valid;
    logic        grant_ack;
    logic [31:0] grant;
    logic [4:0]  grant_idx;
    logic        grant_valid;
    logic [31:0] pending;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b1;

    bus_drive_sequencer #(.N(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .req         (req),
        .req_valid   (req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .grant_ack   (grant_ack),
        .pending     (pending),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a pending set, a round-robin start and the granted
    // index (-1 when nothing is granted).
    typedef struct {
        logic [31:0] pend;
        int          ptr;
        int          gidx;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic clr_n, logic [31:0] r,
                                          logic rv, logic ack);
        model_t      nxt;
        logic [31:0] rin;
        logic [31:0] cand;
        nxt = cur;
        if (!clr_n) begin
            nxt.pend = '0;
            nxt.ptr  = 0;
            nxt.gidx = -1;
            return nxt;
        end
        rin = rv ? r : 32'h0;
        cand = cur.pend | rin;
        if (cur.gidx < 0 || ack) begin
            nxt.gidx = -1;
            nxt.pend = '0;
            for (int k = 0; k < 32; k++) begin
                int j;
                j = (cur.ptr + k) % 32;
                if (nxt.gidx < 0 && cand[j]) begin
                    nxt.gidx = j;
                end
            end
            if (nxt.gidx >= 0) begin
                nxt.pend = cand;
                nxt.pend[nxt.gidx] = 1'b0;
                nxt.ptr = (nxt.gidx + 1) % 32;
            end
        end else begin
            nxt.pend = cand;
        end
        return nxt;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, clr, req, req_valid, grant_ack);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] e_grant;
            logic [4:0]  e_idx;
            logic        e_gv;
            logic        e_busy;
            e_gv    = (m.gidx >= 0);
            e_grant = e_gv ? (32'h1 << m.gidx) : 32'h0;
            e_idx   = e_gv ? 5'(m.gidx) : 5'd0;
            e_busy  = e_gv || (m.pend != 0);
            n_total++;
            if (grant !== e_grant || grant_idx !== e_idx || grant_valid !== e_gv ||
                pending !== m.pend || busy !== e_busy) begin
                $display("FAIL model_cmp t=%0t dut/model grant=%h/%h idx=%0d/%0d gv=%b/%b pend=%h/%h busy=%b/%b",
                         $time, grant, e_grant, grant_idx, e_idx, grant_valid, e_gv,
                         pending, m.pend, busy, e_busy);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [31:0] r, input logic rv, input logic a);
        clr       = c;
        req       = r;
        req_valid = rv;
        grant_ack = a;
    endtask

    initial begin
        // Reset with every request asserted: nothing may leak through.
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        tick();
        check("rst_gv",      32'(grant_valid), 32'h0);
        check("rst_grant",   grant,            32'h0);
        check("rst_idx",     32'(grant_idx),   32'h0);
        check("rst_pending", pending,          32'h0);
        check("rst_busy",    32'(busy),        32'h0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        check("idle_gv", 32'(grant_valid), 32'h0);

        // Single request, held while un-acked, then released.
        drive(1'b1, 32'h0000_0020, 1'b1, 1'b0);
        tick();
        check("single_grant", grant,            32'h0000_0020);
        check("single_idx",   32'(grant_idx),   32'd5);
        check("single_gv",    32'(grant_valid), 32'h1);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_hold", grant, 32'h0000_0020);
        end
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        check("single_done_gv",   32'(grant_valid), 32'h0);
        check("single_done_busy", 32'(busy),        32'h0);

        // Round-robin order with wrap from ptr=0.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8000_0003, 1'b1, 1'b0);
        tick();
        check("rr_idx0", 32'(grant_idx), 32'd0);
        check("rr_pend", pending,        32'h8000_0002);
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        check("rr_idx1", 32'(grant_idx), 32'd1);
        tick();
        check("rr_idx31", 32'(grant_idx), 32'd31);
        tick();
        check("rr_idle", 32'(grant_valid), 32'h0);
        drive(1'b1, 32'h0000_0003, 1'b1, 1'b0);
        tick();
        check("rr_wrap_idx0", 32'(grant_idx), 32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        check("rr_wrap_idle", 32'(grant_valid), 32'h0);

        // Fairness: a re-request of the granted bit goes behind others.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0006, 1'b1, 1'b0);
        tick();
        check("fair_idx1", 32'(grant_idx), 32'd1);
        drive(1'b1, 32'h0000_0002, 1'b1, 1'b1);
        tick();
        check("fair_idx2", 32'(grant_idx), 32'd2);
        check("fair_pend", pending,        32'h0000_0002);
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        check("fair_idx1b", 32'(grant_idx), 32'd1);
        tick();
        check("fair_idle", 32'(grant_valid), 32'h0);

        // Simultaneous request and ack: no bubble, wrapped search from ptr=5.
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0);
        tick();
        check("sim_idx4", 32'(grant_idx), 32'd4);
        check("sim_pend", pending,        32'h0);
        drive(1'b1, 32'h0000_0001, 1'b1, 1'b1);
        tick();
        check("sim_gv",   32'(grant_valid), 32'h1);
        check("sim_idx0", 32'(grant_idx),   32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        tick();

        // Reset mid-grant drops the grant and the queue.
        drive(1'b1, 32'h00F0_0080, 1'b1, 1'b0);
        tick();
        check("mid_idx7", 32'(grant_idx), 32'd7);
        check("mid_pend", pending,        32'h00F0_0000);
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        check("mid_rst_gv",    32'(grant_valid), 32'h0);
        check("mid_rst_grant", grant,            32'h0);
        check("mid_rst_pend",  pending,          32'h0);
        check("mid_rst_busy",  32'(busy),        32'h0);
        drive(1'b1, 32'h0010_0000, 1'b1, 1'b0);
        tick();
        check("mid_idx20", 32'(grant_idx), 32'd20);

        // Randomized traffic with occasional resets; the model compare
        // process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            case ($urandom_range(3))
                0:       r = $urandom & $urandom & $urandom & $urandom;
                1:       r = 32'h1 << $urandom_range(31);
                2:       r = $urandom & $urandom;
                default: r = $urandom;
            endcase
            drive(($urandom_range(63) != 0), r, 1'($urandom_range(1)), 1'($urandom_range(1)));
            tick();
        end

        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
